// File: rtl/pio_in_debounce_irq.sv
`default_nettype none
// ============================================================================
// Module   : pio_in_debounce_irq
// Purpose  : Debounced parallel input port with edge capture and level IRQ,
//            exposed as an Avalon-MM slave.
// Revision : 1.0 - initial release
// ============================================================================
module pio_in_debounce_irq #(
  parameter int WIDTH           = 18,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  input  logic [WIDTH-1:0]  in_port,
  output logic [31:0]       readdata,
  output logic              irq
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] cap_clr;
  logic [31:0]      rd_mux;
  logic             wr_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= in_port;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // The counter tracks how long s has disagreed with stable; reaching the
  // window length commits the new level and raises the edge strobe.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [CNT_W-1:0] cnt_q;
    logic             stable_q;
    logic             differs;
    logic             settle;

    assign differs = s[i] ^ stable_q;
    assign settle  = differs && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q    <= '0;
        stable_q <= 1'b0;
      end else if (!differs) begin
        cnt_q <= '0;
      end else if (settle) begin
        stable_q <= s[i];
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign stable[i] = stable_q;

    if (EDGE_TYPE == 0) begin : g_rise
      assign edge_set[i] = settle & s[i];
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign edge_set[i] = settle & ~s[i];
    end else begin : g_any
      assign edge_set[i] = settle;
    end
  end

  assign wr_en   = chipselect & ~write_n;
  assign cap_clr = (wr_en && (address == ADDR_EDGECAP)) ? writedata[WIDTH-1:0] : '0;

  // Set is OR-ed in after the clear so a coincident capture survives a W1C.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask <= '0;
      edgecap <= '0;
    end else begin
      if (wr_en && (address == ADDR_IRQMASK)) begin
        irqmask <= writedata[WIDTH-1:0];
      end
      edgecap <= (edgecap & ~cap_clr) | edge_set;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:    rd_mux[WIDTH-1:0] = stable;
      ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
      ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edgecap;
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

  assign irq = |(edgecap & irqmask);

endmodule
`default_nettype wire

// File: tb/tb_pio_in_debounce_irq.sv
`default_nettype none
// ============================================================================
// Module   : tb_pio_in_debounce_irq
// Purpose  : Scoreboard bench: reference model predicts readdata/irq per edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pio_in_debounce_irq;

  localparam int W  = 18;
  localparam int S  = 2;
  localparam int D  = 4;
  localparam int ET = 2;

  logic          clk        = 1'b0;
  logic          reset_n    = 1'b0;
  logic [1:0]    address    = 2'd0;
  logic          chipselect = 1'b0;
  logic          write_n    = 1'b1;
  logic [31:0]   writedata  = 32'd0;
  logic [W-1:0]  in_port    = '0;
  logic [31:0]   readdata;
  logic          irq;

  int checks = 0;
  int errors = 0;

  pio_in_debounce_irq #(
    .WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(ET)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: input delay line, then a level flips once the last D
  // delayed samples all disagree with it.
  typedef struct {
    logic [31:0] rd;
    logic        irq;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] m_sync [S];
  logic [W-1:0] m_win  [D];
  logic [W-1:0] m_stable, m_mask, m_cap;

  task automatic model_clear();
    for (int k = 0; k < S; k++) m_sync[k] = '0;
    for (int k = 0; k < D; k++) m_win[k] = '0;
    m_stable = '0;
    m_mask   = '0;
    m_cap    = '0;
  endtask

  task automatic model_step();
    logic [W-1:0] s_pre, flip, nstable, set, clr;
    exp_t e;
    s_pre = m_sync[S-1];
    case (address)
      2'd0:    e.rd = 32'(m_stable);
      2'd2:    e.rd = 32'(m_mask);
      2'd3:    e.rd = 32'(m_cap);
      default: e.rd = 32'd0;
    endcase
    for (int k = D-1; k > 0; k--) m_win[k] = m_win[k-1];
    m_win[0] = s_pre;
    flip = '1;
    for (int k = 0; k < D; k++) flip &= (m_win[k] ^ m_stable);
    nstable = m_stable ^ flip;
    if (ET == 0)      set = flip & nstable;
    else if (ET == 1) set = flip & ~nstable;
    else              set = flip;
    clr = '0;
    if (chipselect && !write_n) begin
      if (address == 2'd2) m_mask = writedata[W-1:0];
      if (address == 2'd3) clr = writedata[W-1:0];
    end
    m_cap    = (m_cap & ~clr) | set;
    m_stable = nstable;
    for (int k = S-1; k > 0; k--) m_sync[k] = m_sync[k-1];
    m_sync[0] = in_port;
    e.irq = |(m_cap & m_mask);
    exp_q.push_back(e);
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        model_clear();
        exp_q.delete();
      end else begin
        model_step();
      end
    end
  end

  // Monitor: readdata is presented every cycle; with nothing predicted the
  // DUT must still be in its reset state.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        chk("rd_reset", readdata, 32'd0);
        chk("irq_reset", {31'd0, irq}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("readdata", readdata, e.rd);
        chk("irq", {31'd0, irq}, {31'd0, e.irq});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = $urandom;
  endtask

  initial begin
    repeat (3) tick();
    @(negedge clk);
    chk("reset_rd", readdata, 32'd0);
    reset_n = 1'b1;
    tick();

    // Rising input: stable flips on the 6th edge, readable one edge later.
    address    = 2'd0;
    in_port[0] = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 6) chk("lat_early", readdata, 32'd0);
      if (n == 7) chk("lat_visible", readdata, 32'd1);
    end
    tick();

    // Three-cycle glitch on bit 3 must leave no trace.
    in_port[3] = 1'b1;
    repeat (3) tick();
    in_port[3] = 1'b0;
    repeat (10) tick();
    address = 2'd0;
    tick();
    @(negedge clk);
    chk("glitch_stable", readdata & 32'h8, 32'd0);
    address = 2'd3;
    tick();
    @(negedge clk);
    chk("glitch_cap", readdata & 32'h8, 32'd0);
    chk("glitch_irq", {31'd0, irq}, 32'd0);

    // Masked edge raises irq; W1C drops it the next cycle.
    wr(2'd3, 32'h3FFFF);
    wr(2'd2, 32'h1);
    in_port[0] = 1'b0;
    repeat (8) tick();
    @(negedge clk);
    chk("irq_set", {31'd0, irq}, 32'd1);
    wr(2'd3, 32'h1);
    @(negedge clk);
    chk("irq_clr", {31'd0, irq}, 32'd0);

    // Pending edge on bit 5 asserts irq as soon as it is unmasked.
    wr(2'd2, 32'h0);
    wr(2'd3, 32'h3FFFF);
    in_port[5] = 1'b1;
    repeat (8) tick();
    @(negedge clk);
    chk("irq_masked", {31'd0, irq}, 32'd0);
    wr(2'd2, 32'h20);
    @(negedge clk);
    chk("irq_unmask", {31'd0, irq}, 32'd1);
    address = 2'd3;
    tick();
    @(negedge clk);
    chk("cap_bit5", readdata, 32'h20);

    // W1C on the very edge bit 2 is captured: set wins.
    wr(2'd3, 32'h3FFFF);
    wr(2'd2, 32'h4);
    in_port[2] = 1'b1;
    repeat (5) tick();
    wr(2'd3, 32'h4);
    @(negedge clk);
    chk("setwins_irq", {31'd0, irq}, 32'd1);
    address = 2'd3;
    tick();
    @(negedge clk);
    chk("setwins_cap", readdata, 32'h4);

    // Reset mid-debounce discards the count; full window after release.
    in_port = '0;
    repeat (10) tick();
    in_port = '1;
    repeat (5) tick();
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_rd", readdata, 32'd0);
    chk("rst_mid_irq", {31'd0, irq}, 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    address = 2'd0;
    for (int n = 1; n <= 7; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 6) chk("rst_lat_early", readdata, 32'd0);
      if (n == 7) chk("rst_lat_visible", readdata, 32'h3FFFF);
    end
    tick();

    // Randomized traffic: sparse input flips (some shorter than the window),
    // random reads/writes and occasional resets.
    for (int c = 0; c < 4000; c++) begin
      address    = 2'($urandom_range(0, 3));
      chipselect = ($urandom_range(0, 3) == 0);
      write_n    = ($urandom_range(0, 2) != 0);
      writedata  = $urandom;
      if ($urandom_range(0, 3) == 0) in_port ^= W'($urandom & $urandom & $urandom);
      reset_n = ($urandom_range(0, 799) != 0);
      tick();
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
    reset_n    = 1'b1;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
